// File: rtl/mdu_arbiter.sv
// Two-port round-robin front end for a shared multiply/divide unit.
// Keeps one operation in flight and completes illegal ops, busy timeouts and aborts.
module mdu_arbiter #(
  parameter int TMO_CYCLES = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  input  logic        abort,
  output logic [3:0]  mdu_op,
  output logic        mdu_start,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo
);

  localparam int CW = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);
  localparam logic [3:0] OP_NONE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state;
  logic          last_grant;
  logic          drop;
  logic [CW-1:0] cnt;

  logic          grant_any;
  logic          grant_port;
  logic [3:0]    sel_op;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;
  logic          op_legal;

  // Round-robin choice: when both ports ask, the one not served last wins.
  always_comb begin
    grant_port = 1'b0;
    case (req_valid)
      2'b01:   grant_port = 1'b0;
      2'b10:   grant_port = 1'b1;
      2'b11:   grant_port = ~last_grant;
      default: grant_port = 1'b0;
    endcase
  end

  assign grant_any = reset && (state == IDLE) && (req_valid != 2'b00);
  assign req_ready = grant_any ? (grant_port ? 2'b10 : 2'b01) : 2'b00;

  assign sel_op   = grant_port ? req_op1 : req_op0;
  assign sel_a    = grant_port ? req_a1  : req_a0;
  assign sel_b    = grant_port ? req_b1  : req_b0;
  assign op_legal = (sel_op[3:2] == 2'b00);

  // An abort seen on the completing cycle still suppresses the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      drop       <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      rsp_err    <= 1'b0;
      mdu_start  <= 1'b0;
      mdu_op     <= OP_NONE;
      mdu_a      <= '0;
      mdu_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant <= grant_port;
            rsp_id     <= grant_port;
            drop       <= 1'b0;
            cnt        <= '0;
            if (op_legal) begin
              state     <= ISSUE;
              mdu_start <= 1'b1;
              mdu_op    <= sel_op;
              mdu_a     <= sel_a;
              mdu_b     <= sel_b;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_hi    <= '0;
              rsp_lo    <= '0;
            end
          end
        end

        ISSUE: begin
          mdu_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT_BUSY;
          if (abort) drop <= 1'b1;
        end

        WAIT_BUSY: begin
          if (abort) drop <= 1'b1;
          if (mdu_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == TMO_LAST) begin
            if (drop || abort) begin
              state  <= IDLE;
              drop   <= 1'b0;
              mdu_op <= OP_NONE;
              mdu_a  <= '0;
              mdu_b  <= '0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_hi    <= '0;
              rsp_lo    <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (abort) drop <= 1'b1;
          if (!mdu_busy) begin
            if (drop || abort) begin
              state  <= IDLE;
              drop   <= 1'b0;
              mdu_op <= OP_NONE;
              mdu_a  <= '0;
              mdu_b  <= '0;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_hi    <= mdu_hi;
              rsp_lo    <= mdu_lo;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            drop      <= 1'b0;
            mdu_op    <= OP_NONE;
            mdu_a     <= '0;
            mdu_b     <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_arbiter.sv
// Scoreboard bench for mdu_arbiter with a small behavioural MDU attached.
// Expected responses are queued at request acceptance and compared at response handshake.
module tb_mdu_arbiter;

  localparam int TMO = 31;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [3:0]  p_op [2];
  logic [31:0] p_a [2];
  logic [31:0] p_b [2];
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;
  logic        abort = 1'b0;
  logic [3:0]  mdu_op;
  logic        mdu_start;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_busy = 1'b0;
  logic [31:0] mdu_hi = '0;
  logic [31:0] mdu_lo = '0;

  typedef struct {
    logic        id;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_pulses = 0;
  int start_cyc = 0;
  int busy_fall_cyc = 0;
  int rsp_first_cyc = 0;
  int rsp_hs_cyc = 0;
  int rsp_count = 0;
  int last_grant_cyc = 0;
  int mdu_lat = 3;
  logic mdu_dead = 1'b0;
  logic expect_drop = 1'b0;
  logic expect_tmo = 1'b0;
  logic rsp_prev = 1'b0;
  logic [63:0] last_data [2];

  mdu_arbiter #(.TMO_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op0   (p_op[0]),
    .req_op1   (p_op[1]),
    .req_a0    (p_a[0]),
    .req_b0    (p_b[0]),
    .req_a1    (p_a[1]),
    .req_b1    (p_b[1]),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_hi    (rsp_hi),
    .rsp_lo    (rsp_lo),
    .rsp_err   (rsp_err),
    .abort     (abort),
    .mdu_op    (mdu_op),
    .mdu_start (mdu_start),
    .mdu_a     (mdu_a),
    .mdu_b     (mdu_b),
    .mdu_busy  (mdu_busy),
    .mdu_hi    (mdu_hi),
    .mdu_lo    (mdu_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: hi holds the upper product word or the remainder.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa, sbv;
    logic [31:0] q, r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sa = a;
    sbv = b;
    case (op)
      4'd0: return 64'(sa64 * sb64);
      4'd1: return {32'b0, a} * {32'b0, b};
      4'd2: begin q = sa / sbv; r = sa % sbv; return {r, q}; end
      4'd3: return {a % b, a / b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) if (reset && mdu_start) start_pulses++;

  // Behavioural MDU: busy rises one cycle after start and falls mdu_lat cycles later.
  always begin
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    @(negedge clk);
    if (reset && mdu_start) begin
      start_cyc = cyc;
      if (!mdu_dead) begin
        m_op = mdu_op;
        m_a = mdu_a;
        m_b = mdu_b;
        @(negedge clk);
        mdu_busy = 1'b1;
        repeat (mdu_lat) @(negedge clk);
        {mdu_hi, mdu_lo} = ref_result(m_op, m_a, m_b);
        mdu_busy = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  // Monitor: push expectations on acceptance, compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      rsp_prev = 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (req_valid[n] && req_ready[n]) begin
          grant_log.push_back(n);
          last_grant_cyc = cyc;
          if (expect_drop) begin
            expect_drop = 1'b0;
          end else begin
            e.id = n[0];
            e.err = (p_op[n][3:2] != 2'b00) || expect_tmo;
            e.data = e.err ? 64'h0 : ref_result(p_op[n], p_a[n], p_b[n]);
            exp_q.push_back(e);
          end
        end
      end
      if (rsp_valid && !rsp_prev) begin
        rsp_first_cyc = cyc;
        rsp_count++;
        if (exp_q.size() == 0) checkOutput("rsp_unexpected", 64'(rsp_valid), 64'h0);
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        rsp_hs_cyc = cyc;
        e = exp_q.pop_front();
        checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
        checkOutput("rsp_data", {rsp_hi, rsp_lo}, e.data);
        checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
        last_data[rsp_id] = {rsp_hi, rsp_lo};
      end
      rsp_prev = rsp_valid;
    end
  end

  task automatic applyStimulus(input int port, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    p_op[port] = op;
    p_a[port] = a;
    p_b[port] = b;
    req_valid[port] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[port]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    if (!ok) checkOutput("grant_timeout", 64'h0, 64'h1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rsp_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) checkOutput({tag, "_timeout"}, 64'h0, 64'h1);
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!mdu_busy && k < 50);
    if (!mdu_busy) checkOutput({tag, "_busy_timeout"}, 64'h0, 64'h1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, r0;
    logic ok;
    p_op[0] = 4'd0; p_a[0] = '0; p_b[0] = '0;
    p_op[1] = 4'd0; p_a[1] = '0; p_b[1] = '0;
    last_data[0] = '0; last_data[1] = '0;

    // Reset values, with both requests asserted so req_ready must still be quiet.
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_rsp_id_err", {62'h0, rsp_id, rsp_err}, 64'h0);
    checkOutput("reset_rsp_data", {rsp_hi, rsp_lo}, 64'h0);
    checkOutput("reset_mdu_start", 64'(mdu_start), 64'h0);
    checkOutput("reset_mdu_op", 64'(mdu_op), 64'hF);
    checkOutput("reset_mdu_ab", {mdu_a, mdu_b}, 64'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Signed multiply on port 0.
    s0 = start_pulses;
    applyStimulus(0, 4'd0, 32'd3, 32'hFFFFFFFE);
    wait_done("mult", 100);
    checkOutput("mult_start_pulses", 64'(start_pulses - s0), 64'd1);
    checkOutput("mult_data_const", last_data[0], 64'hFFFFFFFF_FFFFFFFA);

    // Illegal op on port 1 completes with an error and never starts the MDU.
    s0 = start_pulses;
    applyStimulus(1, 4'h5, 32'd11, 32'd12);
    wait_done("illegal", 50);
    checkOutput("illegal_no_start", 64'(start_pulses - s0), 64'd0);

    // MDU never goes busy: error completion TMO cycles into WAIT_BUSY.
    mdu_dead = 1'b1;
    expect_tmo = 1'b1;
    applyStimulus(0, 4'd1, 32'd5, 32'd6);
    wait_done("tmo", 200);
    checkOutput("tmo_latency", 64'(rsp_first_cyc - (start_cyc + 1)), 64'(TMO));
    expect_tmo = 1'b0;
    mdu_dead = 1'b0;

    // Abort during WAIT_DONE of a DIV; port 1 waits until busy falls.
    mdu_lat = 6;
    r0 = rsp_count;
    expect_drop = 1'b1;
    applyStimulus(0, 4'd2, 32'hFFFFFFF9, 32'd2);
    wait_busy("abort");
    @(posedge clk); #1;
    abort = 1'b1;
    p_op[1] = 4'd1; p_a[1] = 32'h0001_0000; p_b[1] = 32'h0001_0000;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    if (!ok) checkOutput("abort_grant_timeout", 64'h0, 64'h1);
    checkOutput("abort_grant_after_busy", 64'(last_grant_cyc > busy_fall_cyc), 64'h1);
    wait_done("abort", 100);
    checkOutput("abort_rsp_count", 64'(rsp_count - r0), 64'd1);
    mdu_lat = 3;

    // Consumer stalls 5 cycles while port 1 keeps requesting.
    rsp_ready = 1'b0;
    applyStimulus(0, 4'd1, 32'h0000_1234, 32'h0000_0010);
    p_op[1] = 4'd0; p_a[1] = 32'hFFFFFFFB; p_b[1] = 32'd7;
    req_valid[1] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("hold_rsp_timeout", 64'h0, 64'h1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'h1);
      checkOutput("hold_rsp_data", {rsp_hi, rsp_lo}, 64'h0000_0000_0001_2340);
      checkOutput("hold_rsp_id_err", {62'h0, rsp_id, rsp_err}, 64'h0);
      checkOutput("hold_req_ready", 64'(req_ready), 64'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    if (!ok) checkOutput("hold_grant_timeout", 64'h0, 64'h1);
    checkOutput("idle_gap_before_grant", 64'(last_grant_cyc > rsp_hs_cyc), 64'h1);
    wait_done("hold", 100);
    checkOutput("hold_p1_data_const", last_data[1], 64'hFFFFFFFF_FFFFFFDD);

    // Reset in the middle of an operation discards it.
    mdu_lat = 10;
    applyStimulus(0, 4'd0, 32'd9, 32'd9);
    wait_busy("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset_mdu_op", 64'(mdu_op), 64'hF);
    checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    s0 = start_pulses;
    r0 = rsp_count;
    repeat (20) @(negedge clk);
    checkOutput("midreset_no_start", 64'(start_pulses - s0), 64'd0);
    checkOutput("midreset_no_rsp", 64'(rsp_count - r0), 64'd0);
    mdu_lat = 3;

    // Both ports valid continuously: grants alternate starting at port 0.
    grant_log.delete();
    @(posedge clk); #1;
    p_op[0] = 4'd0; p_a[0] = 32'd3; p_b[0] = 32'hFFFFFFFE;
    p_op[1] = 4'd3; p_a[1] = 32'd7; p_b[1] = 32'd2;
    req_valid = 2'b11;
    for (int k = 0; k < 400 && grant_log.size() < 4; k++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_done("rr", 100);
    if (grant_log.size() < 4) begin
      checkOutput("rr_grant_count", 64'(grant_log.size()), 64'd4);
    end else begin
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("rr_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
    end
    checkOutput("rr_p1_divu_const", last_data[1], {32'd1, 32'd3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
